// File: rtl/alu_iterative.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/branch ops, bit-serial shifts
// (one position per cycle) behind a start/busy/done handshake.
module alu_iterative #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            ALU_Operation_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] ALU_Result_o,
  output logic                  Zero_o
);

  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010,
                         OP_OR  = 4'b0011, OP_XOR = 4'b0100, OP_LUI = 4'b0101,
                         OP_SRL = 4'b0110, OP_SLL = 4'b0111, OP_BEQ = 4'b1000,
                         OP_BNE = 4'b1010, OP_BLT = 4'b1011, OP_BGE = 4'b1100,
                         OP_JAL = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_shifted;
  logic [4:0]              cnt_q;
  logic                    left_q;
  logic [DATA_WIDTH-1:0]   result_q;
  logic                    zero_q;

  logic                    accept, is_shift, go_shift, last_shift;
  logic [4:0]              shamt;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic                    alu_zero;

  // A request is taken in IDLE and DONE; during SHIFT it is dropped, not queued.
  assign accept     = start_i && (state_q != S_SHIFT);
  assign shamt      = B_i[4:0];
  assign is_shift   = (ALU_Operation_i == OP_SRL) || (ALU_Operation_i == OP_SLL);
  assign go_shift   = accept && is_shift && (shamt != 5'd0);
  assign last_shift = (state_q == S_SHIFT) && (cnt_q == 5'd1);

  // Single-cycle result; a shift reaching here has k=0, so it passes A through.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    alu_res  = '0;
    alu_zero = 1'b0;
    case (ALU_Operation_i)
      OP_ADD:         alu_res = A_i + B_i;
      OP_SUB:         alu_res = A_i - B_i;
      OP_AND:         alu_res = A_i & B_i;
      OP_OR:          alu_res = A_i | B_i;
      OP_XOR:         alu_res = A_i ^ B_i;
      OP_SRL, OP_SLL: alu_res = A_i;
      OP_LUI:         alu_res = {B_i[19:0], 12'h000};
      OP_JAL:         alu_res = A_i + DATA_WIDTH'(4);
      default:        alu_res = '0;
    endcase
    case (ALU_Operation_i)
      OP_BEQ:  alu_zero = (A_i == B_i);
      OP_BNE:  alu_zero = (A_i != B_i);
      OP_BLT:  alu_zero = ($signed(A_i) <  $signed(B_i));
      OP_BGE:  alu_zero = ($signed(A_i) >= $signed(B_i));
      OP_JAL:  alu_zero = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SRL, OP_SLL, OP_LUI: alu_zero = (alu_res == '0);
      default: alu_zero = 1'b0;
    endcase
  end

  assign shreg_shifted = left_q ? (shreg_q << 1) : (shreg_q >> 1);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = go_shift ? S_SHIFT : S_DONE;
      S_SHIFT: if (last_shift) state_d = S_DONE;
      S_DONE:  state_d = accept ? (go_shift ? S_SHIFT : S_DONE) : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == S_SHIFT);
    done_o = (state_q == S_DONE);
  end

  // NOTE: datapath registers are reset too, so the visible result/flag read 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q  <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else if (accept) begin
      shreg_q <= A_i;
      cnt_q   <= shamt;
      left_q  <= (ALU_Operation_i == OP_SLL);
      if (!go_shift) begin
        result_q <= alu_res;
        zero_q   <= alu_zero;
      end
    end else if (state_q == S_SHIFT) begin
      shreg_q <= shreg_shifted;
      cnt_q   <= cnt_q - 5'd1;
      if (last_shift) begin
        result_q <= shreg_shifted;
        zero_q   <= (shreg_shifted == '0);
      end
    end
  end

  assign ALU_Result_o = result_q;
  assign Zero_o       = zero_q;

endmodule

// File: tb/tb_alu_iterative.sv
// Scoreboard bench for alu_iterative: stimulus pushes expected results with their
// due cycle; a negedge monitor pops and compares on every done_o.
module tb_alu_iterative;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [3:0]  ALU_Operation_i;
  logic [31:0] A_i, B_i;
  logic        busy_o, done_o, Zero_o;
  logic [31:0] ALU_Result_o;

  alu_iterative #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .ALU_Operation_i(ALU_Operation_i),
    .A_i(A_i), .B_i(B_i), .busy_o(busy_o), .done_o(done_o),
    .ALU_Result_o(ALU_Result_o), .Zero_o(Zero_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    bit          chk_zero;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   busy_lo = -1, busy_hi = -1;
  bit   mon_en = 1'b0;
  int   n_tests = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: busy window and every done_o are compared against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      check("busy_o", {31'b0, busy_o}, {31'b0, (cyc >= busy_lo) && (cyc <= busy_hi)});
      if (done_o) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", {31'b0, done_o}, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check({e.name, " result"}, ALU_Result_o, e.res);
          if (e.chk_zero) check({e.name, " zero"}, {31'b0, Zero_o}, {31'b0, e.zero});
          check({e.name, " latency"}, cyc, e.cyc);
        end
      end
    end
  end

  // Called just after a rising edge; drives start for one cycle (cycle N).
  task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic zero,
                       input bit chk_zero);
    exp_t e;
    int   k;
    k = ((op == 4'b0110) || (op == 4'b0111)) ? int'(b[4:0]) : 0;
    start_i = 1'b1; ALU_Operation_i = op; A_i = a; B_i = b;
    e.res = res; e.zero = zero; e.chk_zero = chk_zero; e.cyc = cyc + 1 + k; e.name = name;
    sb_q.push_back(e);
    if (k > 0) begin
      busy_lo = cyc + 1;
      busy_hi = cyc + k;
    end
    @(posedge clk); #1;
    start_i = 1'b0; A_i = $urandom; B_i = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    if (sb_q.size() != 0) begin
      check("done_timeout", {31'b0, done_o}, 32'd1);
      sb_q.delete();
    end
  endtask

  initial begin
    reset = 1'b1; start_i = 1'b0; ALU_Operation_i = '0; A_i = '0; B_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy_o", {31'b0, busy_o}, 32'd0);
    check("reset done_o", {31'b0, done_o}, 32'd0);
    check("reset result", ALU_Result_o, 32'd0);
    check("reset zero", {31'b0, Zero_o}, 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    issue("add 5+7",    4'b0000, 32'd5,        32'd7,        32'd12,       1'b0, 1); drain();
    issue("sub equal",  4'b0001, 32'h8000_0000, 32'h8000_0000, 32'd0,      1'b1, 1); drain();
    issue("add wrap",   4'b0000, 32'hFFFF_FFFF, 32'd1,        32'd0,        1'b1, 1); drain();
    issue("and",        4'b0010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1); drain();
    issue("or",         4'b0011, 32'h0000_1200, 32'h0000_0034, 32'h0000_1234, 1'b0, 1); drain();
    issue("xor self",   4'b0100, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'd0,       1'b1, 1); drain();
    issue("sll 1<<31",  4'b0111, 32'd1,        32'd31,       32'h8000_0000, 1'b0, 0); drain();
    issue("srl k=0",    4'b0110, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 0); drain();
    issue("srl 4",      4'b0110, 32'h8000_0000, 32'd4,        32'h0800_0000, 1'b0, 0); drain();
    issue("lui",        4'b0101, 32'd0,        32'h000A_BCDE, 32'hABCD_E000, 1'b0, 0); drain();
    issue("blt -1<1",   4'b1011, 32'hFFFF_FFFF, 32'd1,        32'd0,        1'b1, 1); drain();
    issue("bge -1>=1",  4'b1100, 32'hFFFF_FFFF, 32'd1,        32'd0,        1'b0, 1); drain();
    issue("blt 1<-1",   4'b1011, 32'd1,        32'hFFFF_FFFF, 32'd0,        1'b0, 1); drain();
    issue("bne 3,3",    4'b1010, 32'd3,        32'd3,        32'd0,        1'b0, 1); drain();
    issue("beq 3,3",    4'b1000, 32'd3,        32'd3,        32'd0,        1'b1, 1); drain();
    issue("jal",        4'b1101, 32'h0000_1000, 32'h1234_5678, 32'h0000_1004, 1'b1, 1); drain();
    issue("undef 1111", 4'b1111, 32'd9,        32'd9,        32'd0,        1'b0, 1); drain();
    issue("undef 1001", 4'b1001, 32'd0,        32'd0,        32'd0,        1'b0, 1); drain();

    // Back-to-back: second start is held during the first op's DONE cycle.
    issue("b2b add",    4'b0000, 32'd1,        32'd2,        32'd3,        1'b0, 1);
    issue("b2b sub",    4'b0001, 32'd10,       32'd3,        32'd7,        1'b0, 1);
    drain();

    // A start pulse mid-shift must neither disturb the shift nor produce a done.
    issue("sll 3<<5",   4'b0111, 32'd3,        32'd5,        32'h0000_0060, 1'b0, 0);
    @(posedge clk); #1;
    start_i = 1'b1; ALU_Operation_i = 4'b0000; A_i = 32'd1; B_i = 32'd1;
    @(posedge clk); #1;
    start_i = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    #1;

    // Reset in cycle N+3 of SRL k=10 aborts with no done_o.
    issue("srl abort",  4'b0110, 32'hF000_0000, 32'd10,       32'h003C_0000, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    busy_hi = cyc;
    sb_q.delete();
    @(posedge clk); #1;
    check("abort busy_o", {31'b0, busy_o}, 32'd0);
    check("abort done_o", {31'b0, done_o}, 32'd0);
    check("abort result", ALU_Result_o, 32'd0);
    check("abort zero", {31'b0, Zero_o}, 32'd0);
    reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;

    issue("add after reset", 4'b0000, 32'd2, 32'd2, 32'd4, 1'b0, 1); drain();
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
